nios2_uart_tx_ctrl: RTL and testbench

NIOS2_UART_TX_CTRL -- requirements
Module: nios2_uart_tx_ctrl

---
 rtl/nios2_uart_tx_ctrl_if.sv | 25 ++
 rtl/nios2_uart_tx_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_nios2_uart_tx_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_uart_tx_ctrl_if.sv
// Avalon-MM slave bus bundle for the Nios II UART transmit controller.
// The CPU side drives the master modport; the controller uses the slave modport.
interface nios2_uart_tx_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_uart_tx_ctrl.sv
// Avalon-MM UART transmitter: byte FIFO feeding an 8N1 serializer with programmable divisor.
// Define NIOS2_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module nios2_uart_tx_ctrl #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    nios2_uart_tx_ctrl_if.slave        bus,
    output logic                       txd,
    output logic                       irq
);

    localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW      = 5;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]     DIV_RST = 16'(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef NIOS2_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // A programmed divisor of zero would stall the bit timer, so it behaves as one.
    function automatic logic [15:0] f_eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    state_t          r_state;
    logic [15:0]     r_timer;
    logic [15:0]     r_div_lat;
    logic [15:0]     r_divisor;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_txd;
    logic            r_irq;
    logic            r_ovr;
    logic            r_ien;
    logic [31:0]     r_readdata;
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
`ifdef NIOS2_UART_TX_PARITY_EN
    logic            r_parity;
`endif

    wire         w_wr         = bus.chipselect & ~bus.write_n;
    wire         w_wr_txdata  = w_wr & (bus.address == 2'd0);
    wire         w_wr_status  = w_wr & (bus.address == 2'd1);
    wire         w_wr_div     = w_wr & (bus.address == 2'd2);
    wire         w_wr_ctrl    = w_wr & (bus.address == 2'd3);
    wire         w_bit_end    = (r_timer == 16'd0);
    wire         w_empty      = (r_count == '0);
    wire         w_full       = (r_count == DEPTH_C);
    wire         w_busy       = (r_state != S_IDLE);
    wire [15:0]  w_div_new    = f_eff_div(r_divisor);
    wire [7:0]   w_head       = r_fifo[r_rd_ptr];
    wire         w_unused     = &{1'b0, bus.writedata[31:16]};

    // Frame starts from IDLE, or straight out of the last STOP cycle so frames abut.
    wire w_pop  = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    wire w_push = w_wr_txdata & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.writedata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Register file; a dropped byte setting OVR beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_divisor <= DIV_RST;
            r_ien     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_wr_div)  r_divisor <= bus.writedata[15:0];
            if (w_wr_ctrl) r_ien     <= bus.writedata[0];
            if (w_wr_txdata & ~w_push)
                r_ovr <= 1'b1;
            else if (w_wr_status & bus.writedata[3])
                r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            case (bus.address)
                2'd1:    r_readdata <= {23'd0, r_count, r_ovr, w_empty, w_full, w_busy};
                2'd2:    r_readdata <= {16'd0, r_divisor};
                2'd3:    r_readdata <= {31'd0, r_ien};
                default: r_readdata <= 32'd0;
            endcase
            r_irq <= r_ien & w_empty & ~w_busy;
        end
    end

    // Serializer: each bit cell lasts r_div_lat cycles, counted down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_txd     <= 1'b1;
            r_timer   <= 16'd0;
            r_div_lat <= 16'd1;
            r_shift   <= 8'd0;
            r_bitcnt  <= 3'd0;
`ifdef NIOS2_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift   <= w_head;
`ifdef NIOS2_UART_TX_PARITY_EN
            r_parity  <= ^w_head;
`endif
            r_div_lat <= w_div_new;
            r_timer   <= w_div_new - 16'd1;
            r_txd     <= 1'b0;
            r_state   <= S_START;
        end else if (w_busy && !w_bit_end) begin
            r_timer <= r_timer - 16'd1;
        end else begin
            r_timer <= r_div_lat - 16'd1;
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                end
                S_START: begin
                    r_txd    <= r_shift[0];
                    r_shift  <= {1'b0, r_shift[7:1]};
                    r_bitcnt <= 3'd0;
                    r_state  <= S_DATA;
                end
                S_DATA: begin
                    if (r_bitcnt == 3'd7) begin
`ifdef NIOS2_UART_TX_PARITY_EN
                        r_txd   <= r_parity;
                        r_state <= S_PARITY;
`else
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
`endif
                    end else begin
                        r_txd    <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
`ifdef NIOS2_UART_TX_PARITY_EN
                S_PARITY: begin
                    r_txd   <= 1'b1;
                    r_state <= S_STOP;
                end
`endif
                S_STOP: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.readdata = r_readdata;
    assign txd          = r_txd;
    assign irq          = r_irq;

endmodule

// File: tb/tb_nios2_uart_tx_ctrl.sv
// Self-checking bench for nios2_uart_tx_ctrl: serial waveforms are predicted cell by cell
// from byte values, divisors and frame format, and compared against captured txd.
`timescale 1ns/1ps
module tb_nios2_uart_tx_ctrl;
    localparam int CLK_DIV = 434;
    localparam int DEPTH   = 4;
`ifdef NIOS2_UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic txd;
    logic irq;
    int   n_cmp   = 0;
    int   n_err   = 0;

    nios2_uart_tx_ctrl_if bus();

    nios2_uart_tx_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .txd     (txd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d required finish", n_cmp);
        $fatal(1, "watchdog");
    end

    // Waveform capture and reference stream
    logic       cap_en = 1'b0;
    logic       cap_txd[$];
    logic [8:0] cap_st[$];
    logic       exp_q[$];

    always @(negedge clk) begin
        if (cap_en) begin
            cap_txd.push_back(txd);
            cap_st.push_back(bus.readdata[8:0]);
        end
    end

    task automatic start_capture();
        cap_txd.delete();
        cap_st.delete();
        exp_q.delete();
        cap_en = 1'b1;
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        int   d;
        logic bits[$];
        d = (div == 0) ? 1 : div;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef NIOS2_UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) repeat (d) exp_q.push_back(bits[k]);
    endtask

    task automatic add_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    function automatic int wave_start();
        for (int i = 0; i < cap_txd.size(); i++)
            if (cap_txd[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int wave_diff(input int s);
        if (s < 0) return -2;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (s + i >= cap_txd.size()) return i;
            if (cap_txd[s + i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic obs_at(input int idx);
        if (idx < 0 || idx >= cap_txd.size()) return 1'bx;
        return cap_txd[idx];
    endfunction

    function automatic logic exp_at(input int idx);
        if (idx < 0 || idx >= exp_q.size()) return 1'bx;
        return exp_q[idx];
    endfunction

    // Bus helpers: all start and end just after a rising edge
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(posedge clk);
        #1;
        d = bus.readdata;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: observed %b expected 1", txd); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: observed %b expected 0", irq); end
        n_cmp++;
        if (bus.readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: observed %h expected 0", bus.readdata); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_cycles(1);
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL reset_status: observed %h expected 00000004", d); end
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'(CLK_DIV)) begin n_err++; $display("FAIL reset_divisor: observed %0d expected %0d", d, CLK_DIV); end
        rd(2'd3, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL reset_control: observed %h expected 0", d); end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL reset_txdata_read: observed %h expected 0", d); end
    endtask

    task automatic test_single_frame();
        int s, dd, bad;
        logic [31:0] d;
        wr(2'd2, 32'd4);
        start_capture();
        wr(2'd0, 32'h55);
        bus.address = 2'd1;
        add_frame(8'h55, 4);
        add_idle(4);
        wait_cycles(FBITS * 4 + 12);
        cap_en = 1'b0;
        s  = wave_start();
        dd = wave_diff(s);
        n_cmp++;
        if (dd != -1) begin
            n_err++;
            $display("FAIL single_0x55: txd at frame cycle %0d observed %b expected %b", dd, obs_at(s + dd), exp_at(dd));
        end
        bad = -1;
        if (s >= 0)
            for (int i = s + 1; i < s + FBITS * 4 && i < cap_st.size(); i++)
                if (bad < 0 && (cap_st[i][0] !== 1'b1 || cap_st[i][2] !== 1'b1)) bad = i - s;
        n_cmp++;
        if (s < 0 || bad >= 0) begin
            n_err++;
            $display("FAIL single_busy_empty: at frame cycle %0d BUSY/EMPTY observed %b/%b expected 1/1",
                     bad, (s >= 0 && bad >= 0) ? cap_st[s + bad][0] : 1'bx, (s >= 0 && bad >= 0) ? cap_st[s + bad][2] : 1'bx);
        end
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL single_status_after: observed %h expected 00000004", d); end
    endtask

    task automatic test_back_to_back();
        int s, dd, idx;
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        wr(2'd2, 32'd4);
        start_capture();
        for (int k = 0; k < 3; k++) wr(2'd0, {24'd0, bytes[k]});
        bus.address = 2'd1;
        for (int k = 0; k < 3; k++) add_frame(bytes[k], 4);
        add_idle(4);
        wait_cycles(3 * FBITS * 4 + 12);
        cap_en = 1'b0;
        s  = wave_start();
        dd = wave_diff(s);
        n_cmp++;
        if (dd != -1) begin
            n_err++;
            $display("FAIL b2b_frames: txd at stream cycle %0d observed %b expected %b", dd, obs_at(s + dd), exp_at(dd));
        end
        if (s >= 0)
            for (int k = 0; k < 3; k++) begin
                idx = s + k * FBITS * 4 + FBITS * 2;
                n_cmp++;
                if (idx >= cap_st.size() || cap_st[idx][8:4] !== 5'(2 - k)) begin
                    n_err++;
                    $display("FAIL b2b_count_frame%0d: observed %0d expected %0d", k,
                             (idx < cap_st.size()) ? cap_st[idx][8:4] : 5'bx, 2 - k);
                end
            end
    endtask

    task automatic test_div_change();
        int s, dd;
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        wr(2'd2, 32'd4);
        start_capture();
        wr(2'd0, {24'd0, a});
        wr(2'd0, {24'd0, b});
        wait_cycles(14);
        wr(2'd2, 32'd8);
        add_frame(a, 4);
        add_frame(b, 8);
        add_idle(4);
        wait_cycles(FBITS * 4 + FBITS * 8);
        cap_en = 1'b0;
        s  = wave_start();
        dd = wave_diff(s);
        n_cmp++;
        if (dd != -1) begin
            n_err++;
            $display("FAIL div_change_%h_%h: txd at stream cycle %0d observed %b expected %b", a, b, dd, obs_at(s + dd), exp_at(dd));
        end
    endtask

    task automatic test_parity();
        int s, dd;
        wr(2'd2, 32'd3);
        start_capture();
        wr(2'd0, 32'h07);
        wr(2'd0, 32'h03);
        add_frame(8'h07, 3);
        add_frame(8'h03, 3);
        add_idle(4);
        wait_cycles(2 * FBITS * 3 + 12);
        cap_en = 1'b0;
        s  = wave_start();
        dd = wave_diff(s);
        n_cmp++;
        if (dd != -1) begin
            n_err++;
            $display("FAIL frame_format_07_03: txd at stream cycle %0d observed %b expected %b", dd, obs_at(s + dd), exp_at(dd));
        end
    endtask

    task automatic test_random();
        int s, dd, div, n, deff;
        logic [7:0] b;
        for (int it = 0; it < 5; it++) begin
            div  = (it == 0) ? 0 : $urandom_range(1, 5);
            n    = $urandom_range(1, 3);
            deff = (div == 0) ? 1 : div;
            wr(2'd2, 32'(div));
            start_capture();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                wr(2'd0, {24'd0, b});
                add_frame(b, div);
            end
            add_idle(3);
            wait_cycles(n * FBITS * deff + 14);
            cap_en = 1'b0;
            s  = wave_start();
            dd = wave_diff(s);
            n_cmp++;
            if (dd != -1) begin
                n_err++;
                $display("FAIL random_%0d_div%0d: txd at stream cycle %0d observed %b expected %b", it, div, dd, obs_at(s + dd), exp_at(dd));
            end
        end
    endtask

    task automatic test_irq();
        wr(2'd3, 32'd1);
        wait_cycles(2);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_idle_enabled: observed %b expected 1", irq); end
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h5A);
        wait_cycles(3);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_while_busy: observed %b expected 0", irq); end
        wait_cycles(FBITS * 2 + 4);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_after_frame: observed %b expected 1", irq); end
        wr(2'd3, 32'd0);
        wait_cycles(2);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_disabled: observed %b expected 0", irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, expst;
        int nwr, cnt;
        logic ovr;
        nwr = 6;
        wr(2'd2, 32'd40);
        wr(2'd0, 32'hFF);
        wait_cycles(3);
        for (int k = 0; k < nwr; k++) wr(2'd0, 32'($urandom_range(0, 255)));
        cnt   = (nwr < DEPTH) ? nwr : DEPTH;
        ovr   = (nwr > DEPTH);
        expst = 32'((cnt << 4) | (int'(ovr) << 3) | (int'(cnt == 0) << 2) | (int'(cnt == DEPTH) << 1) | 1);
        rd(2'd1, d);
        n_cmp++;
        if (d !== expst) begin n_err++; $display("FAIL ovf_status: observed %h expected %h", d, expst); end
        wr(2'd1, 32'h0);
        rd(2'd1, d);
        n_cmp++;
        if (d !== expst) begin n_err++; $display("FAIL ovf_keep_sticky: observed %h expected %h", d, expst); end
        wr(2'd1, 32'h8);
        rd(2'd1, d);
        expst[3] = 1'b0;
        n_cmp++;
        if (d !== expst) begin n_err++; $display("FAIL ovf_clear: observed %h expected %h", d, expst); end
        do_reset();
    endtask

    task automatic test_reset_midframe();
        int t;
        logic [31:0] d;
        logic irq_seen;
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h55);
        t = 0;
        while (txd !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        n_cmp++;
        if (txd !== 1'b0) begin n_err++; $display("FAIL midreset_start: txd observed %b expected 0 within 20 cycles", txd); end
        repeat (17) @(negedge clk);
        n_cmp++;
        if (txd !== 1'b0) begin n_err++; $display("FAIL midreset_bit3: txd observed %b expected 0", txd); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (txd !== 1'b1) begin n_err++; $display("FAIL midreset_txd_async: observed %b expected 1", txd); end
        wait_cycles(2);
        reset_n = 1'b1;
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h4) begin n_err++; $display("FAIL midreset_status: observed %h expected 00000004", d); end
        irq_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cycles(1);
            if (irq !== 1'b0) irq_seen = 1'b1;
        end
        n_cmp++;
        if (irq_seen !== 1'b0) begin n_err++; $display("FAIL midreset_irq_off: observed 1 expected 0"); end
        wr(2'd3, 32'd1);
        t = 0;
        while (irq !== 1'b1 && t < 4) begin wait_cycles(1); t++; end
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL midreset_irq_on: observed %b expected 1", irq); end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_change();
        test_parity();
        test_random();
        test_irq();
        test_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
